// File: rtl/pipeline_skid_stage_pkg.sv
// Shared processor constants and helpers for pipeline boundary stages.
package pipeline_skid_stage_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned OCC_W = 2;

  // Canonical RISC-V NOP (addi x0,x0,0), also used by control and immediate extend.
  localparam logic [XLEN-1:0] NOP_INSN = 32'h0000_0013;

  function automatic logic [OCC_W-1:0] occ_count(input logic main_v, input logic skid_v);
    return OCC_W'(main_v) + OCC_W'(skid_v);
  endfunction

endpackage

// File: rtl/pipeline_skid_stage.sv
// Two-entry skid buffer used as a pipeline register between core stages.
// in_ready depends only on registered state, which breaks the ready path between stages.
module pipeline_skid_stage
  import pipeline_skid_stage_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] BUBBLE_VALUE = DATA_WIDTH'(NOP_INSN)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [OCC_W-1:0]      occupancy
);

  logic                  main_valid_q, main_valid_d;
  logic                  skid_valid_q, skid_valid_d;
  logic [DATA_WIDTH-1:0] main_data_q, main_data_d;
  logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;
  logic                  in_fire;
  logic                  out_fire;

  // Next-state: the skid entry only ever fills behind a valid main entry.
  always_comb begin
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_data_d  = main_data_q;
    skid_data_d  = skid_data_q;
    in_fire      = in_valid && !skid_valid_q;
    out_fire     = main_valid_q && out_ready;

    if (out_fire) begin
      if (skid_valid_q) begin
        main_data_d  = skid_data_q;
        skid_valid_d = 1'b0;
      end else if (in_fire) begin
        main_data_d  = in_data;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (in_fire) begin
      if (main_valid_q) begin
        skid_data_d  = in_data;
        skid_valid_d = 1'b1;
      end else begin
        main_data_d  = in_data;
        main_valid_d = 1'b1;
      end
    end

    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  // Payload registers carry no reset; the valid bits qualify them.
  always_ff @(posedge clk) begin
    main_data_q <= main_data_d;
    skid_data_q <= skid_data_d;
  end

  assign in_ready  = !skid_valid_q;
  assign out_valid = main_valid_q;
  assign out_data  = main_valid_q ? main_data_q : BUBBLE_VALUE;
  assign occupancy = occ_count(main_valid_q, skid_valid_q);

endmodule

// File: tb/tb_pipeline_skid_stage.sv
// Directed and randomized checks of pipeline_skid_stage against a FIFO-queue reference model.
module tb_pipeline_skid_stage;

  localparam logic [31:0] BUBBLE = 32'h0000_0013;
  localparam int unsigned DEPTH  = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [1:0]  occupancy;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Reference: the stage is a bounded FIFO of DEPTH words.
  logic [31:0] mq[$];
  bit          stall_exp;
  logic [31:0] stall_head;

  pipeline_skid_stage dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    logic [31:0] head;
    head = (mq.size() > 0) ? mq[0] : BUBBLE;
    check({tag, ".out_valid"}, 32'(out_valid), 32'(mq.size() > 0));
    check({tag, ".out_data"},  out_data, head);
    check({tag, ".occupancy"}, 32'(occupancy), 32'(mq.size()));
    check({tag, ".in_ready"},  32'(in_ready), 32'(mq.size() < DEPTH));
    if (stall_exp) check({tag, ".stall_hold"}, out_data, stall_head);
  endtask

  // One clock: apply inputs, advance the model at the edge, sample 1 time unit later.
  task automatic cycle(input logic iv, input logic [31:0] d, input logic ordy, input logic fl,
                       input string tag);
    bit in_fire, out_fire;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    in_fire    = iv && (mq.size() < DEPTH);
    out_fire   = ordy && (mq.size() > 0);
    stall_exp  = !ordy && !fl && (mq.size() > 0);
    stall_head = (mq.size() > 0) ? mq[0] : BUBBLE;
    if (fl) begin
      mq.delete();
    end else begin
      if (out_fire) void'(mq.pop_front());
      if (in_fire) mq.push_back(d);
    end
    #1;
    check_model(tag);
  endtask

  initial begin
    rst       = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    stall_exp = 1'b0;
    #3;
    check("reset.out_valid", 32'(out_valid), 32'd0);
    check("reset.out_data",  out_data, BUBBLE);
    check("reset.occupancy", 32'(occupancy), 32'd0);
    check("reset.in_ready",  32'(in_ready), 32'd1);
    @(posedge clk);
    #2 rst = 1'b1;

    // Streaming with out_ready held high: one-cycle latency, no gaps.
    cycle(1'b1, 32'h11, 1'b1, 1'b0, "stream0");
    check("stream0.data", out_data, 32'h11);
    cycle(1'b1, 32'h22, 1'b1, 1'b0, "stream1");
    check("stream1.data", out_data, 32'h22);
    check("stream1.occ",  32'(occupancy), 32'd1);
    cycle(1'b1, 32'h33, 1'b1, 1'b0, "stream2");
    check("stream2.data", out_data, 32'h33);
    cycle(1'b0, 32'hDEAD, 1'b1, 1'b0, "stream_drain");
    check("stream_drain.data", out_data, BUBBLE);

    // Stall fill: third word is held back upstream.
    cycle(1'b1, 32'hA1, 1'b0, 1'b0, "fill0");
    cycle(1'b1, 32'hA2, 1'b0, 1'b0, "fill1");
    check("fill1.occ",      32'(occupancy), 32'd2);
    check("fill1.in_ready", 32'(in_ready), 32'd0);
    cycle(1'b1, 32'hA3, 1'b0, 1'b0, "fill2");
    check("fill2.data", out_data, 32'hA1);
    cycle(1'b1, 32'hA3, 1'b1, 1'b0, "release0");
    check("release0.data", out_data, 32'hA2);
    cycle(1'b1, 32'hA3, 1'b1, 1'b0, "release1");
    check("release1.data", out_data, 32'hA3);
    cycle(1'b0, 32'h0, 1'b1, 1'b0, "release2");
    check("release2.occ", 32'(occupancy), 32'd0);

    // Flush while full, with a word offered in the same cycle.
    cycle(1'b1, 32'hB1, 1'b0, 1'b0, "pfill0");
    cycle(1'b1, 32'hB2, 1'b0, 1'b0, "pfill1");
    cycle(1'b1, 32'hBEEF, 1'b0, 1'b1, "flush_full");
    check("flush_full.occ",  32'(occupancy), 32'd0);
    check("flush_full.data", out_data, BUBBLE);
    cycle(1'b0, 32'h0, 1'b1, 1'b0, "post_flush0");
    check("post_flush0.data", out_data, BUBBLE);
    // Flush with one entry and in_ready high: offered word is still discarded.
    cycle(1'b1, 32'hC1, 1'b0, 1'b0, "one0");
    cycle(1'b1, 32'hBEEF, 1'b1, 1'b1, "flush_one");
    check("flush_one.valid", 32'(out_valid), 32'd0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0, "post_flush1");
    check("post_flush1.data", out_data, BUBBLE);

    // Asynchronous reset mid-cycle while full.
    cycle(1'b1, 32'hD1, 1'b0, 1'b0, "afill0");
    cycle(1'b1, 32'hD2, 1'b0, 1'b0, "afill1");
    #2 rst = 1'b0;
    #1;
    check("areset.out_valid", 32'(out_valid), 32'd0);
    check("areset.occupancy", 32'(occupancy), 32'd0);
    check("areset.out_data",  out_data, BUBBLE);
    check("areset.in_ready",  32'(in_ready), 32'd1);
    mq.delete();
    stall_exp = 1'b0;
    @(posedge clk);
    #3 rst = 1'b1;
    cycle(1'b1, 32'h55, 1'b1, 1'b0, "after_reset");
    check("after_reset.data", out_data, 32'h55);

    // Randomized valid/ready/flush traffic against the queue model.
    for (int i = 0; i < 10000; i++) begin
      cycle(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 63) == 0), "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_skid_stage.md
PIPELINE_SKID_STAGE -- requirements
Module: pipeline_skid_stage

Interface
REQ-001 SHALL have a single clock; reset is asynchronous and active-low.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, giving the payload width in bits (instruction or PC word).
REQ-003 SHALL have parameter BUBBLE_VALUE, default 32'h0000_0013 (RISC-V NOP, addi x0,x0,0), giving the value driven on out_data when the stage is empty.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port rst  input  1  asynchronous reset, active low.
REQ-006 SHALL have port flush  input  1  synchronous kill of all held entries (branch/jump redirect).
REQ-007 SHALL have port in_valid  input  1  upstream offers in_data.
REQ-008 SHALL have port in_ready  output  1  stage can accept this cycle.
REQ-009 SHALL have port in_data  input  DATA_WIDTH  upstream payload.
REQ-010 SHALL have port out_valid  output  1  out_data holds a live entry.
REQ-011 SHALL have port out_ready  input  1  downstream consumes this cycle (low = stall).
REQ-012 SHALL have port out_data  output  DATA_WIDTH  oldest held payload, or BUBBLE_VALUE when empty.
REQ-013 SHALL have port occupancy  output  2  number of held entries, 0..2.

Function
REQ-014 SHALL hold two entries: main (drives outputs) and skid (overflow), each with a valid bit.
REQ-015 SHALL transfer on input when in_valid && in_ready, and on output when out_valid && out_ready, at the rising clk edge.
REQ-016 SHALL drive in_ready = !skid_valid, from a register only, with no combinational path from out_ready.
REQ-017 SHALL drive out_valid = main_valid and out_data = main_valid ? main_data : BUBBLE_VALUE, both from registers.
REQ-018 SHALL give latency in_data -> out_data of exactly 1 cycle when empty or when the output transfers in the same cycle.
REQ-019 SHALL sustain one transfer per cycle when out_ready is held high (no bubbles).
REQ-020 SHALL follow these state transitions (EMPTY/ONE/FULL = occupancy 0/1/2):
  - EMPTY + in -> ONE.
  - ONE + in + out -> ONE (main replaced).
  - ONE + in, no out -> FULL (new word goes to skid).
  - ONE + out, no in -> EMPTY.
  - FULL + out -> ONE (skid moves to main).
  - FULL, no out -> FULL.
REQ-021 SHALL preserve strict FIFO order and never drop or duplicate a transferred word.
REQ-022 SHALL keep out_data and out_valid stable while out_valid && !out_ready.
REQ-023 SHALL, on flush, clear both valid bits at the edge and discard any word offered in that cycle; out_data = BUBBLE_VALUE and in_ready = 1 on the next cycle.
REQ-024 SHALL give flush priority over simultaneous in/out transfers; an output transfer in the flush cycle still counts as consumed by downstream.
REQ-025 SHALL ignore in_data when in_valid is low and retain stored data unchanged.

Reset
REQ-026 SHALL, while rst is low, asynchronously force out_valid = 0, occupancy = 0, out_data = BUBBLE_VALUE, in_ready = 1.
REQ-027 SHALL abandon any in-flight entry on reset mid-operation and accept input again on the first rising edge after rst deasserts.
REQ-028 SHALL reset only the valid bits; data registers need not be reset.

Structure
REQ-029 SHALL take BUBBLE_VALUE's default, the NOP encoding, from the shared processor package constant, which is also used by control/extend.
REQ-030 SHALL be implemented flat with no sub-module; the core instantiates it per boundary (IF/ID, ID/EX, etc.) in place of the plain pipeline register.

Verification
REQ-031 SHALL verify streaming: out_ready = 1 and words 0x11, 0x22, 0x33 on consecutive cycles -> the same words appear on out_data one cycle later, with no gaps and occupancy staying 1.
REQ-032 SHALL verify stall fill: out_ready = 0, then offer 0xA1, 0xA2, 0xA3 -> occupancy reaches 2, in_ready drops, 0xA3 is held upstream and out_data stays 0xA1; releasing out_ready -> 0xA1, 0xA2, 0xA3 come out in order.
REQ-033 SHALL verify flush when full: occupancy 2, assert flush with in_valid = 1 and data 0xBEEF -> next cycle occupancy = 0, out_data = 0x00000013, and 0xBEEF never appears.
REQ-034 SHALL verify async reset: drop rst mid-cycle while full -> out_valid falls immediately without waiting for clk; after release, the first offered word appears after 1 cycle.
REQ-035 SHALL verify random valid/ready: 10,000 cycles against a scoreboard queue -> zero order, drop or duplicate errors, in_ready == (occupancy < 2) every cycle, and out_data stable during stalls.
